cpu_axi_bridge: RTL



---
 rtl/cpu_axi_bridge.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge
//   Merges the CPU instruction-fetch port (read-only) and load/store port
//   (read/write) onto one AXI master with a single transaction in flight.
//   The data port has priority over fetch. Each accepted request gets
//   exactly one data_ok pulse, in acceptance order.
// Ports
//   clk, resetn                      clock, synchronous active-low reset
//   inst_req/addr/addr_ok/data_ok/rdata            fetch port
//   data_req/wr/size/addr/wstrb/wdata/addr_ok/data_ok/rdata  load/store port
//   ar*, r*, aw*, w*, b*             AXI master channels (single beat)
module cpu_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q;            // 1 = transaction belongs to the data port
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        acc_d, acc_i, aw_hs, w_hs;

  // Acceptance is combinational in IDLE; held off while reset is asserted.
  assign acc_d        = resetn & (state_q == S_IDLE) & data_req;
  assign acc_i        = resetn & (state_q == S_IDLE) & inst_req & ~data_req;
  assign data_addr_ok = acc_d;
  assign inst_addr_ok = acc_i;

  assign aw_hs = ~aw_done_q & awready;
  assign w_hs  = ~w_done_q & wready;

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_d)      state_d = data_wr ? S_AW_W : S_AR;
        else if (acc_i) state_d = S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) state_d = S_RESP;
      end
      S_AW_W: begin
        // AW and W complete independently; move on once both have.
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = S_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_d = S_RESP;
      end
      S_RESP: begin
        inst_data_ok = ~owner_q;
        data_data_ok = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (acc_d) begin
        owner_q <= 1'b1;
        addr_q  <= data_addr;
        size_q  <= data_size;
        wstrb_q <= data_wstrb;
        wdata_q <= data_wdata;
      end else if (acc_i) begin
        owner_q <= 1'b0;
        addr_q  <= inst_addr;
        size_q  <= 2'd2;
        wstrb_q <= '0;
        wdata_q <= '0;
      end
      if (state_q == S_R && rvalid) begin
        if (owner_q) data_rdata_q <= rdata;
        else         inst_rdata_q <= rdata;
      end
    end
  end

  assign araddr     = addr_q;
  assign arsize     = {1'b0, size_q};
  assign awaddr     = addr_q;
  assign awsize     = {1'b0, size_q};
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // Single-beat INCR bursts with a fixed ID.
  assign arid    = 4'd0;
  assign awid    = 4'd0;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;
endmodule
